// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: pipeline stage register with flush/hold/load priority, stage FSM,
// saturating stall/flush counters and a sticky stall-run watchdog.
module pipe_stage_reg #(
  parameter int          CTRL_W    = 8,
  parameter int          CNT_W     = 16,
  parameter int          TIMEOUT   = 64,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              enable_i,
  input  logic              flush_ni,
  input  logic              clr_cnt_i,
  input  logic              valid_i,
  input  logic [31:0]       pc_i,
  input  logic [31:0]       instr_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic              valid_o,
  output logic [31:0]       pc_o,
  output logic [31:0]       instr_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [1:0]        state_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o,
  output logic              stall_timeout_o
);
  localparam logic [1:0] EMPTY  = 2'd0;
  localparam logic [1:0] FULL   = 2'd1;
  localparam logic [1:0] HOLD   = 2'd2;
  localparam logic [1:0] BUBBLE = 2'd3;
  localparam int RUN_W = $clog2(TIMEOUT + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(TIMEOUT);
  logic             flush, stall;
  logic [1:0]       state_nx;
  logic [RUN_W-1:0] run, run_nx;
  logic [CNT_W-1:0] stall_cnt_nx, flush_cnt_nx;
  // A hold with no valid instruction keeps EMPTY/BUBBLE as they are.
  always_comb begin
    flush        = !flush_ni;
    stall        = flush_ni && !enable_i;
    state_nx     = flush ? BUBBLE : !enable_i ? (valid_o ? HOLD : state_o) : (valid_i ? FULL : EMPTY);
    run_nx       = !stall ? '0 : (run == RUN_MAX) ? run : run + RUN_W'(1);
    stall_cnt_nx = stall_cnt_o + CNT_W'(stall && stall_cnt_o != '1);
    flush_cnt_nx = flush_cnt_o + CNT_W'(flush && flush_cnt_o != '1);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_o         <= 1'b0;
      pc_o            <= '0;
      instr_o         <= NOP_INSTR;
      ctrl_o          <= '0;
      state_o         <= EMPTY;
      stall_cnt_o     <= '0;
      flush_cnt_o     <= '0;
      run             <= '0;
      stall_timeout_o <= 1'b0;
    end else begin
      state_o <= state_nx;
      if (flush) begin
        valid_o <= 1'b0;
        pc_o    <= '0;
        instr_o <= NOP_INSTR;
        ctrl_o  <= '0;
      end else if (enable_i) begin
        valid_o <= valid_i;
        pc_o    <= pc_i;
        instr_o <= instr_i;
        ctrl_o  <= ctrl_i;
      end
      if (clr_cnt_i) begin
        stall_cnt_o     <= '0;
        flush_cnt_o     <= '0;
        run             <= '0;
        stall_timeout_o <= 1'b0;
      end else begin
        stall_cnt_o     <= stall_cnt_nx;
        flush_cnt_o     <= flush_cnt_nx;
        run             <= run_nx;
        stall_timeout_o <= stall_timeout_o || (run_nx == RUN_MAX);
      end
    end
  end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed and random stimulus against a behavioural model,
// with a second narrow-counter instance for saturation.
module tb_pipe_stage_reg;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int TO = 64;
  logic clk = 1'b0;
  logic rst_n, en, fl_n, clr, vin;
  logic [31:0] pci, ini;
  logic [7:0] cti;
  logic v_o, v4_o;
  logic [31:0] pc_o, in_o, pc4_o, in4_o;
  logic [7:0] ct_o, ct4_o;
  logic [1:0] st_o, st4_o;
  logic [15:0] sc_o, fc_o;
  logic [3:0] sc4_o, fc4_o;
  logic to_o, to4_o;
  int total = 0, bad = 0;
  logic m_v;
  logic [31:0] m_pc, m_in;
  logic [7:0] m_ct;
  logic [1:0] m_st;
  int m_sc, m_fc, m_run;
  logic m_to;
  always #5 clk = ~clk;
  pipe_stage_reg dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .flush_ni(fl_n), .clr_cnt_i(clr),
    .valid_i(vin), .pc_i(pci), .instr_i(ini), .ctrl_i(cti),
    .valid_o(v_o), .pc_o(pc_o), .instr_o(in_o), .ctrl_o(ct_o), .state_o(st_o),
    .stall_cnt_o(sc_o), .flush_cnt_o(fc_o), .stall_timeout_o(to_o));
  pipe_stage_reg #(.CNT_W(4)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .flush_ni(fl_n), .clr_cnt_i(clr),
    .valid_i(vin), .pc_i(pci), .instr_i(ini), .ctrl_i(cti),
    .valid_o(v4_o), .pc_o(pc4_o), .instr_o(in4_o), .ctrl_o(ct4_o), .state_o(st4_o),
    .stall_cnt_o(sc4_o), .flush_cnt_o(fc4_o), .stall_timeout_o(to4_o));
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic int sat(input int v, input int w);
    return (v > (1 << w) - 1) ? (1 << w) - 1 : v;
  endfunction
  task automatic model_reset();
    m_v = 0; m_pc = 0; m_in = NOP; m_ct = 0; m_st = 2'd0;
    m_sc = 0; m_fc = 0; m_run = 0; m_to = 0;
  endtask
  task automatic model_edge();
    if (!fl_n) begin
      m_v = 0; m_pc = 0; m_in = NOP; m_ct = 0; m_st = 2'd3;
    end else if (!en) begin
      if (m_v) m_st = 2'd2;
    end else begin
      m_v = vin; m_pc = pci; m_in = ini; m_ct = cti; m_st = vin ? 2'd1 : 2'd0;
    end
    if (clr) begin
      m_sc = 0; m_fc = 0; m_run = 0; m_to = 0;
    end else begin
      if (!fl_n) m_fc++;
      if (fl_n && !en) begin
        m_sc++;
        m_run = (m_run < TO) ? m_run + 1 : TO;
      end else m_run = 0;
      if (m_run == TO) m_to = 1;
    end
  endtask
  task automatic check_all(input string tag);
    chk({tag, ".valid"}, v_o, m_v);
    chk({tag, ".pc"}, pc_o, m_pc);
    chk({tag, ".instr"}, in_o, m_in);
    chk({tag, ".ctrl"}, ct_o, m_ct);
    chk({tag, ".state"}, st_o, m_st);
    chk({tag, ".stall_cnt"}, sc_o, sat(m_sc, 16));
    chk({tag, ".flush_cnt"}, fc_o, sat(m_fc, 16));
    chk({tag, ".timeout"}, to_o, m_to);
    chk({tag, ".stall_cnt4"}, sc4_o, sat(m_sc, 4));
    chk({tag, ".flush_cnt4"}, fc4_o, sat(m_fc, 4));
    chk({tag, ".timeout4"}, to4_o, m_to);
  endtask
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(tag);
  endtask
  task automatic drive(input logic e, input logic f, input logic c, input logic v,
                       input logic [31:0] p, input logic [31:0] i, input logic [7:0] k);
    en = e; fl_n = f; clr = c; vin = v; pci = p; ini = i; cti = k;
  endtask
  initial begin
    rst_n = 0;
    drive(1, 1, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst_n = 1;
    drive(1, 1, 0, 1, 32'h100, 32'h0050_0093, 8'h5a);
    step("load");
    chk("load.pc_const", pc_o, 64'h100);
    chk("load.state_const", st_o, 64'd1);
    for (int n = 0; n < 3; n++) begin
      drive(0, 1, 0, 1, $urandom, $urandom, 8'($urandom));
      step("hold");
    end
    chk("hold.stall3", sc_o, 64'd3);
    chk("hold.state_const", st_o, 64'd2);
    drive(1, 1, 0, 1, 32'h104, 32'h0010_0113, 8'h33);
    step("reload");
    drive(0, 0, 0, 1, $urandom, $urandom, 8'($urandom));
    step("flush_stall");
    chk("flush.instr_const", in_o, 64'h13);
    chk("flush.fcnt_const", fc_o, 64'd1);
    for (int n = 0; n < TO; n++) begin
      drive(0, 1, 0, $urandom_range(0, 1), $urandom, $urandom, 8'($urandom));
      step(n == TO - 1 ? "stall_64" : "stall_run");
      if (n == TO - 2) chk("stall_63.no_timeout", to_o, 64'd0);
    end
    chk("stall_64.timeout", to_o, 64'd1);
    drive(1, 1, 0, 1, 32'h200, 32'h0000_0033, 8'h01);
    step("post_stall");
    chk("post_stall.sticky", to_o, 64'd1);
    drive(1, 1, 1, 1, 32'h204, 32'h0000_0033, 8'h02);
    step("clr");
    chk("clr.timeout", to_o, 64'd0);
    chk("clr.stall_cnt", sc_o, 64'd0);
    for (int n = 0; n < 20; n++) begin
      drive($urandom_range(0, 1), 0, 0, 1, $urandom, $urandom, 8'($urandom));
      step("flush_sat");
    end
    chk("flush_sat.cnt4", fc4_o, 64'd15);
    chk("flush_sat.cnt16", fc_o, 64'd20);
    drive(1, 0, 1, 1, $urandom, $urandom, 8'($urandom));
    step("clr_flush");
    chk("clr_flush.cnt4", fc4_o, 64'd0);
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0, $urandom_range(0, 31) == 0,
            $urandom_range(0, 1), $urandom, $urandom, 8'($urandom));
      step("rand");
    end
    drive(1, 1, 0, 1, 32'h300, 32'h0030_0193, 8'h77);
    step("pre_hold");
    drive(0, 1, 0, 1, $urandom, $urandom, 8'($urandom));
    step("hold2");
    step("hold3");
    #2 rst_n = 0;
    #1 model_reset();
    check_all("async_reset");
    chk("async_reset.state", st_o, 64'd0);
    @(negedge clk);
    rst_n = 1;
    drive(1, 1, 0, 0, 32'h400, 32'h0000_0013, 8'h00);
    step("after_reset");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
